// File: rtl/full_sub.sv
// Registered WIDTH-bit ripple-borrow subtractor: {barrow,diff} = a - b - cin.
// One-cycle latency; no backpressure, a new operand set is accepted every cycle.
module full_sub #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             in_valid,
    output logic [WIDTH-1:0] diff,
    output logic             barrow,
    output logic             out_valid
);

    logic [WIDTH:0]   bchain;
    logic [WIDTH-1:0] diff_c;

    assign bchain[0] = cin;

    // Each bit is one full-subtractor cell; borrow ripples from LSB to MSB.
    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        assign diff_c[i]   = a[i] ^ b[i] ^ bchain[i];
        assign bchain[i+1] = (~a[i] & b[i]) | (~a[i] & bchain[i]) | (b[i] & bchain[i]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            diff      <= '0;
            barrow    <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                diff   <= diff_c;
                barrow <= bchain[WIDTH];
            end
        end
    end

endmodule

// File: tb/tb_full_sub.sv
// Self-checking bench for full_sub at WIDTH = 1, 8 and 32 against an arithmetic reference.
module tb_full_sub;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [63:0] a_r;
    logic [63:0] b_r;
    logic        cin;
    logic        iv;

    logic [0:0]  d1;
    logic [7:0]  d8;
    logic [31:0] d32;
    logic        bo1, bo8, bo32;
    logic        ov1, ov8, ov32;

    int checks = 0;
    int errors = 0;

    longint unsigned ed [3];
    logic            eb [3];
    logic            ev;
    int              ws [3] = '{1, 8, 32};

    always #5 clk = ~clk;

    full_sub #(.WIDTH(1)) u_w1 (
        .clk(clk), .rst_n(rst_n), .a(a_r[0:0]), .b(b_r[0:0]), .cin(cin), .in_valid(iv),
        .diff(d1), .barrow(bo1), .out_valid(ov1)
    );
    full_sub #(.WIDTH(8)) u_w8 (
        .clk(clk), .rst_n(rst_n), .a(a_r[7:0]), .b(b_r[7:0]), .cin(cin), .in_valid(iv),
        .diff(d8), .barrow(bo8), .out_valid(ov8)
    );
    full_sub #(.WIDTH(32)) u_w32 (
        .clk(clk), .rst_n(rst_n), .a(a_r[31:0]), .b(b_r[31:0]), .cin(cin), .in_valid(iv),
        .diff(d32), .barrow(bo32), .out_valid(ov32)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference: plain unsigned integer subtraction, truncated to the operand width.
    function automatic void ref_sub(input int w, input longint unsigned a, input longint unsigned b,
                                    input logic c, output longint unsigned d, output logic bo);
        longint unsigned mask = (64'd1 << w) - 64'd1;
        longint unsigned am   = a & mask;
        longint unsigned bm   = b & mask;
        longint unsigned cv   = {63'd0, c};
        d  = (am - bm - cv) & mask;
        bo = (am < bm + cv);
    endfunction

    task automatic compare_all();
        check("ov1", {63'd0, ov1}, {63'd0, ev});
        check("ov8", {63'd0, ov8}, {63'd0, ev});
        check("ov32", {63'd0, ov32}, {63'd0, ev});
        check("d1", {63'd0, d1}, ed[0]);
        check("d8", {56'd0, d8}, ed[1]);
        check("d32", {32'd0, d32}, ed[2]);
        check("bo1", {63'd0, bo1}, {63'd0, eb[0]});
        check("bo8", {63'd0, bo8}, {63'd0, eb[1]});
        check("bo32", {63'd0, bo32}, {63'd0, eb[2]});
    endtask

    task automatic model_reset();
        ev = 1'b0;
        for (int i = 0; i < 3; i++) begin
            ed[i] = 0;
            eb[i] = 1'b0;
        end
    endtask

    // One clock: update the model from the inputs sampled at the edge, then compare 1 ns later.
    task automatic step();
        @(posedge clk);
        if (!rst_n) begin
            model_reset();
        end else begin
            ev = iv;
            if (iv) begin
                for (int i = 0; i < 3; i++) ref_sub(ws[i], a_r, b_r, cin, ed[i], eb[i]);
            end
        end
        #1;
        compare_all();
    endtask

    task automatic drive(input logic [63:0] a, input logic [63:0] b, input logic c, input logic v);
        a_r = a;
        b_r = b;
        cin = c;
        iv  = v;
    endtask

    logic [1:0] tt [8] = '{2'b00, 2'b11, 2'b11, 2'b01, 2'b10, 2'b00, 2'b00, 2'b11};

    initial begin
        rst_n = 1'b0;
        drive(64'd0, 64'd0, 1'b0, 1'b0);
        model_reset();
        #1;
        compare_all();

        // In reset, a valid input must be ignored.
        drive(64'h55, 64'h3, 1'b1, 1'b1);
        step();
        check("rst_ignore_ov8", {63'd0, ov8}, 64'd0);
        rst_n = 1'b1;

        // WIDTH=1 exhaustive truth table, back-to-back.
        for (int i = 0; i < 8; i++) begin
            drive({63'd0, i[2]}, {63'd0, i[1]}, i[0], 1'b1);
            step();
            check("tt_d", {63'd0, d1}, {63'd0, tt[i][1]});
            check("tt_b", {63'd0, bo1}, {63'd0, tt[i][0]});
            check("tt_ov", {63'd0, ov1}, 64'd1);
        end

        // Wrap-around: 0 - 0 - 1.
        drive(64'd0, 64'd0, 1'b1, 1'b1);
        step();
        check("wrap_d8", {56'd0, d8}, 64'hFF);
        check("wrap_b8", {63'd0, bo8}, 64'd1);
        check("wrap_ov8", {63'd0, ov8}, 64'd1);
        check("wrap_d32", {32'd0, d32}, 64'hFFFF_FFFF);

        // No borrow.
        drive(64'hA5, 64'h25, 1'b1, 1'b1);
        step();
        check("nob_d8", {56'd0, d8}, 64'h7F);
        check("nob_b8", {63'd0, bo8}, 64'd0);

        // a = b, cin = 0 and a = 0, b = all ones, cin = 1.
        drive(64'h0000_0000_C3C3_C3C3, 64'h0000_0000_C3C3_C3C3, 1'b0, 1'b1);
        step();
        check("eq_d32", {32'd0, d32}, 64'd0);
        check("eq_b32", {63'd0, bo32}, 64'd0);
        drive(64'd0, 64'hFFFF_FFFF, 1'b1, 1'b1);
        step();
        check("max_d8", {56'd0, d8}, 64'd0);
        check("max_b8", {63'd0, bo8}, 64'd1);
        check("max_d32", {32'd0, d32}, 64'd0);

        // Hold while in_valid is low.
        drive(64'd3, 64'd1, 1'b0, 1'b1);
        step();
        check("hold_cap_d8", {56'd0, d8}, 64'd2);
        for (int i = 0; i < 3; i++) begin
            drive(64'h77 + 64'(i), 64'h99, 1'b1, 1'b0);
            step();
            check("hold_d8", {56'd0, d8}, 64'd2);
            check("hold_ov8", {63'd0, ov8}, 64'd0);
        end

        // Asynchronous reset between edges, with an input in flight.
        drive(64'd9, 64'd2, 1'b0, 1'b1);
        step();
        check("pre_rst_d8", {56'd0, d8}, 64'd7);
        drive(64'h40, 64'h11, 1'b0, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check("arst_d8", {56'd0, d8}, 64'd0);
        check("arst_d32", {32'd0, d32}, 64'd0);
        check("arst_ov8", {63'd0, ov8}, 64'd0);
        step();
        rst_n = 1'b1;
        drive(64'h40, 64'h11, 1'b0, 1'b0);
        step();
        check("discard_ov8", {63'd0, ov8}, 64'd0);
        check("discard_d8", {56'd0, d8}, 64'd0);

        // Randomized run, with occasional boundary operands.
        for (int n = 0; n < 1000; n++) begin
            a_r = {$urandom, $urandom};
            b_r = {$urandom, $urandom};
            case ($urandom_range(0, 7))
                0: b_r = a_r;
                1: a_r = 64'd0;
                2: b_r = '1;
                default: ;
            endcase
            cin = 1'($urandom_range(0, 1));
            iv  = ($urandom_range(0, 3) != 0);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
